// File: rtl/axi4_lite_req_arbiter_if.sv
`default_nettype none
// =============================================================================
// axi4_lite_req_arbiter_if : requester-side and AXI4-Lite-master-side signals
// Rev 1.0
// =============================================================================
interface axi4_lite_req_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            done;
  logic                          err;
  logic [DATA_WIDTH-1:0]         rdata;
  logic                          m_rd_en;
  logic                          m_wr_en;
  logic [ADDR_WIDTH-1:0]         m_raddr;
  logic [ADDR_WIDTH-1:0]         m_waddr;
  logic [DATA_WIDTH-1:0]         m_wdata;
  logic                          m_rvalid;
  logic                          m_rready;
  logic [DATA_WIDTH-1:0]         m_rdata;
  logic                          m_bvalid;
  logic                          m_bready;

  // Arbiter view
  modport master (
    input  req, req_we, req_addr, req_wdata,
    input  m_rvalid, m_rready, m_rdata, m_bvalid, m_bready,
    output gnt, done, err, rdata,
    output m_rd_en, m_wr_en, m_raddr, m_waddr, m_wdata
  );

  // Requesters plus AXI4-Lite master view
  modport slave (
    output req, req_we, req_addr, req_wdata,
    output m_rvalid, m_rready, m_rdata, m_bvalid, m_bready,
    input  gnt, done, err, rdata,
    input  m_rd_en, m_wr_en, m_raddr, m_waddr, m_wdata
  );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_req_arbiter.sv
`default_nettype none
// =============================================================================
// axi4_lite_req_arbiter : round-robin sharing of one AXI4-Lite master, one txn at a time
// Rev 1.0
// =============================================================================
module axi4_lite_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                     ACLK,
  input  logic                     ARESETN,
  axi4_lite_req_arbiter_if.master  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]   C_CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0]   C_PTR_RST  = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] C_ONE      = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      r_last;
  logic                  r_we;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic [IDX_W-1:0]      w_pick;
  logic                  w_pick_vld;
  int                    w_pos;
  logic                  w_cpl;
  logic                  w_tmo;
  logic [NUM_REQ-1:0]    w_idx_oh;

  // Scan downward in distance so the closest requester after r_last wins.
  always_comb begin
    w_pick     = '0;
    w_pick_vld = 1'b0;
    w_pos      = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_pos = (int'(r_last) + k) % NUM_REQ;
      if (bus.req[w_pos]) begin
        w_pick     = IDX_W'(w_pos);
        w_pick_vld = 1'b1;
      end
    end
  end

  assign w_cpl = r_we ? (bus.m_bvalid & bus.m_bready) : (bus.m_rvalid & bus.m_rready);
  assign w_tmo = (r_cnt == C_CNT_LAST);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_pick_vld) w_state_nxt = S_ISSUE;
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT:  if (w_cpl || w_tmo) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Master-facing address/data are loaded on the grant edge so they are valid throughout ISSUE.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_idx   <= '0;
      r_last  <= C_PTR_RST;
      r_we    <= 1'b0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
      r_raddr <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_idx <= w_pick;
            r_we  <= bus.req_we[w_pick];
            if (bus.req_we[w_pick]) begin
              r_waddr <= bus.req_addr[int'(w_pick)*ADDR_WIDTH +: ADDR_WIDTH];
              r_wdata <= bus.req_wdata[int'(w_pick)*DATA_WIDTH +: DATA_WIDTH];
            end else begin
              r_raddr <= bus.req_addr[int'(w_pick)*ADDR_WIDTH +: ADDR_WIDTH];
            end
          end
        end
        S_ISSUE: begin
          r_cnt <= '0;
        end
        S_WAIT: begin
          if (w_cpl) begin
            if (!r_we) r_rdata <= bus.m_rdata;
            r_err <= 1'b0;
          end else if (w_tmo) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_last <= r_idx;
        end
        default: ;
      endcase
    end
  end

  assign w_idx_oh    = C_ONE << r_idx;
  assign bus.gnt     = (r_state != S_IDLE) ? w_idx_oh : '0;
  assign bus.done    = (r_state == S_DONE) ? w_idx_oh : '0;
  assign bus.err     = (r_state == S_DONE) & r_err;
  assign bus.rdata   = r_rdata;
  assign bus.m_rd_en = (r_state == S_ISSUE) & ~r_we;
  assign bus.m_wr_en = (r_state == S_ISSUE) & r_we;
  assign bus.m_raddr = r_raddr;
  assign bus.m_waddr = r_waddr;
  assign bus.m_wdata = r_wdata;

endmodule
`default_nettype wire
